// File: rtl/pipelined_memory.sv
// pipelined_memory
// Single-port word memory with byte-enabled writes and a fixed-latency
// read pipeline. One read and one write may be accepted every cycle.
// Nothing pushes back on the requester.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   rst_n      : asynchronous active-low reset (pipeline only, not storage)
//   data_in    : write data
//   addr       : word address; any bit at or above ADDR_BITS set = out of range
//   wr, rd     : write / read requests, sampled every rising edge
//   byte_en    : per-byte write enable, bit i covers data bits [8i+7:8i]
//   data_out   : read data, zero whenever available is low
//   available  : one-cycle pulse, READ_LATENCY cycles after an accepted read
//   write_done : one-cycle pulse, the cycle after an accepted write
//   addr_err   : the write and/or read responding this cycle was out of range
module pipelined_memory #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_BITS    = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [31:0]             addr,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    available,
    output logic                    write_done,
    output logic                    addr_err
);

    localparam int DEPTH  = 1 << ADDR_BITS;
    localparam int NBYTES = DATA_WIDTH / 8;

    // True when any address bit above the implemented range is set.
    function automatic logic addr_out_of_range(input logic [31:0] a);
        return ((a >> ADDR_BITS) != 32'd0);
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic                 oor_s;
    logic [ADDR_BITS-1:0] idx_s;
    logic                 last_err_in_s;

    // Read pipeline. Stage 1 holds the array read and stage READ_LATENCY
    // drives the outputs.
    logic [READ_LATENCY:1] vld_r;
    logic [READ_LATENCY:1] err_r;
    logic [DATA_WIDTH-1:0] dat_r [1:READ_LATENCY];

    logic write_done_r;
    logic addr_err_r;

    assign oor_s = addr_out_of_range(addr);
    assign idx_s = addr[ADDR_BITS-1:0];

    // Error flag that enters the output stage at the next edge. With a
    // single stage, that flag comes straight from the incoming request.
    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign last_err_in_s = rd && oor_s;
        end else begin : g_latn
            assign last_err_in_s = err_r[READ_LATENCY-1];
        end
    endgenerate

    // Storage write. The array is never reset. Because the write is
    // non-blocking, a same-cycle read in stage 1 sees the old contents.
    always_ff @(posedge clk) begin
        if (wr && !oor_s) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (byte_en[i]) begin
                    mem_r[idx_s][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline. An out-of-range or idle slot carries zero data, so
    // data_out is zero whenever available is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= {READ_LATENCY{1'b0}};
            err_r <= {READ_LATENCY{1'b0}};
            for (int k = 1; k <= READ_LATENCY; k++) begin
                dat_r[k] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            vld_r[1] <= rd;
            err_r[1] <= rd && oor_s;
            if (rd && !oor_s) begin
                dat_r[1] <= mem_r[idx_s];
            end else begin
                dat_r[1] <= {DATA_WIDTH{1'b0}};
            end
            for (int k = 2; k <= READ_LATENCY; k++) begin
                vld_r[k] <= vld_r[k-1];
                err_r[k] <= err_r[k-1];
                dat_r[k] <= dat_r[k-1];
            end
        end
    end

    // Write acknowledge, plus addr_err as the OR of the write and read
    // responses that land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_done_r <= 1'b0;
            addr_err_r   <= 1'b0;
        end else begin
            write_done_r <= wr;
            addr_err_r   <= (wr && oor_s) || last_err_in_s;
        end
    end

    assign available  = vld_r[READ_LATENCY];
    assign data_out   = dat_r[READ_LATENCY];
    assign write_done = write_done_r;
    assign addr_err   = addr_err_r;

endmodule

// File: tb/tb_pipelined_memory.sv
// Bench for pipelined_memory. Three instances (READ_LATENCY 2, 1, 4) share
// one stimulus stream. A cycle-indexed response schedule predicts what each
// instance must show after every edge. Directed scenarios add literal
// expectations on the latency-2 instance.
module tb_pipelined_memory;

    localparam int NC = 4096;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] addr    = 32'd0;
    logic        wr      = 1'b0;
    logic        rd      = 1'b0;
    logic [3:0]  byte_en = 4'd0;

    logic [95:0] do_all;
    logic [2:0]  av_all;
    logic [2:0]  wd_all;
    logic [2:0]  ae_all;

    always #5 clk = ~clk;

    pipelined_memory #(.DATA_WIDTH(32), .ADDR_BITS(12), .READ_LATENCY(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr(addr), .wr(wr), .rd(rd),
        .byte_en(byte_en), .data_out(do_all[31:0]), .available(av_all[0]),
        .write_done(wd_all[0]), .addr_err(ae_all[0]));

    pipelined_memory #(.DATA_WIDTH(32), .ADDR_BITS(12), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr(addr), .wr(wr), .rd(rd),
        .byte_en(byte_en), .data_out(do_all[63:32]), .available(av_all[1]),
        .write_done(wd_all[1]), .addr_err(ae_all[1]));

    pipelined_memory #(.DATA_WIDTH(32), .ADDR_BITS(12), .READ_LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr(addr), .wr(wr), .rd(rd),
        .byte_en(byte_en), .data_out(do_all[95:64]), .available(av_all[2]),
        .write_done(wd_all[2]), .addr_err(ae_all[2]));

    int lat [3] = '{2, 1, 4};

    // Model state. e counts rising edges. Index i of each schedule holds
    // what the outputs must be between edge i and edge i+1.
    int        e = 0;
    bit [31:0] mmem    [4096];
    bit        exp_av  [3][NC];
    bit [31:0] exp_dat [3][NC];
    bit        exp_rerr[3][NC];
    bit        exp_wd  [NC];
    bit        exp_werr[NC];

    // Literal expectations for the latency-2 instance.
    bit        lit_chk_av [NC];
    bit        lit_av     [NC];
    bit        lit_chk_dat[NC];
    bit [31:0] lit_dat    [NC];
    bit        lit_chk_wd [NC];
    bit        lit_chk_ae [NC];
    bit        lit_ae     [NC];

    int errors = 0;
    int checks = 0;

    // Reference model: a read at edge e answers after edge e+L-1 and a write
    // is acknowledged after edge e. Reset drops everything in flight.
    always @(posedge clk) begin : model_p
        bit inr;
        int ai;
        int idx;
        e   = e + 1;
        inr = (addr[31:12] == 20'd0);
        ai  = int'(addr[11:0]);
        if (!rst_n) begin
            for (int j = 0; j < 5; j++) begin
                exp_wd[e+j]   = 1'b0;
                exp_werr[e+j] = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    exp_av[k][e+j]   = 1'b0;
                    exp_dat[k][e+j]  = 32'd0;
                    exp_rerr[k][e+j] = 1'b0;
                end
            end
        end else begin
            if (rd) begin
                for (int k = 0; k < 3; k++) begin
                    idx = e + lat[k] - 1;
                    exp_av[k][idx]   = 1'b1;
                    exp_dat[k][idx]  = inr ? mmem[ai] : 32'd0;
                    exp_rerr[k][idx] = !inr;
                end
            end
            if (wr) begin
                exp_wd[e]   = 1'b1;
                exp_werr[e] = !inr;
                if (inr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byte_en[b]) mmem[ai][8*b +: 8] = data_in[8*b +: 8];
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] got,
                       input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s lat=%0d edge=%0d got=%h expected=%h", nm, lat[k], e, got, expv);
        end
    endtask

    // Compare every instance against the model on every falling edge.
    always @(negedge clk) begin : compare_p
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                chk("reset_available",  k, {31'd0, av_all[k]}, 32'd0);
                chk("reset_data_out",   k, do_all[32*k +: 32], 32'd0);
                chk("reset_write_done", k, {31'd0, wd_all[k]}, 32'd0);
                chk("reset_addr_err",   k, {31'd0, ae_all[k]}, 32'd0);
            end else begin
                chk("available",  k, {31'd0, av_all[k]}, {31'd0, exp_av[k][e]});
                chk("data_out",   k, do_all[32*k +: 32], exp_dat[k][e]);
                chk("write_done", k, {31'd0, wd_all[k]}, {31'd0, exp_wd[e]});
                chk("addr_err",   k, {31'd0, ae_all[k]},
                    {31'd0, exp_werr[e] | exp_rerr[k][e]});
            end
        end
        if (rst_n) begin
            if (lit_chk_av[e])  chk("lit_available",  0, {31'd0, av_all[0]}, {31'd0, lit_av[e]});
            if (lit_chk_dat[e]) chk("lit_data_out",   0, do_all[31:0], lit_dat[e]);
            if (lit_chk_wd[e])  chk("lit_write_done", 0, {31'd0, wd_all[0]}, 32'd1);
            if (lit_chk_ae[e])  chk("lit_addr_err",   0, {31'd0, ae_all[0]}, {31'd0, lit_ae[e]});
        end
    end

    task automatic drive(input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        #1;
        wr      = w;
        rd      = r;
        addr    = a;
        data_in = d;
        byte_en = be;
    endtask

    // A read driven now lands on the latency-2 outputs two edges later.
    task automatic lit_read(input logic [31:0] d, input bit ae);
        lit_chk_av[e+2]  = 1'b1;
        lit_av[e+2]      = 1'b1;
        lit_chk_dat[e+2] = 1'b1;
        lit_dat[e+2]     = d;
        lit_chk_ae[e+2]  = 1'b1;
        lit_ae[e+2]      = ae;
    endtask

    task automatic lit_write(input bit ae);
        lit_chk_wd[e+1] = 1'b1;
        lit_chk_ae[e+1] = 1'b1;
        lit_ae[e+1]     = ae;
    endtask

    initial begin
        int rel;
        logic [31:0] ra;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Fill the locations the random phase will read.
        for (int a = 0; a < 32; a++) drive(1'b1, 1'b0, a, $urandom, 4'hF);

        // Full-word write then read back.
        drive(1'b1, 1'b0, 32'h005, 32'hDEADBEEF, 4'hF); lit_write(1'b0);
        drive(1'b0, 1'b1, 32'h005, 32'd0, 4'h0);        lit_read(32'hDEADBEEF, 1'b0);

        // Partial byte write.
        drive(1'b1, 1'b0, 32'h007, 32'h11223344, 4'hF);
        drive(1'b1, 1'b0, 32'h007, 32'hAABBCCDD, 4'h5);
        drive(1'b0, 1'b1, 32'h007, 32'd0, 4'h0);        lit_read(32'h11BB33DD, 1'b0);

        // Back-to-back reads.
        drive(1'b1, 1'b0, 32'h001, 32'hA1A1A1A1, 4'hF);
        drive(1'b1, 1'b0, 32'h002, 32'hA2A2A2A2, 4'hF);
        drive(1'b1, 1'b0, 32'h003, 32'hA3A3A3A3, 4'hF);
        drive(1'b0, 1'b1, 32'h001, 32'd0, 4'h0);        lit_read(32'hA1A1A1A1, 1'b0);
        drive(1'b0, 1'b1, 32'h002, 32'd0, 4'h0);        lit_read(32'hA2A2A2A2, 1'b0);
        drive(1'b0, 1'b1, 32'h003, 32'd0, 4'h0);        lit_read(32'hA3A3A3A3, 1'b0);

        // Simultaneous read and write to one address returns old data.
        drive(1'b1, 1'b0, 32'h010, 32'h00000000, 4'hF);
        drive(1'b1, 1'b1, 32'h010, 32'h12345678, 4'hF); lit_read(32'h00000000, 1'b0);
        drive(1'b0, 1'b1, 32'h010, 32'd0, 4'h0);        lit_read(32'h12345678, 1'b0);

        // Out-of-range write and read.
        drive(1'b1, 1'b0, 32'h000, 32'hCAFEF00D, 4'hF);
        drive(1'b1, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF); lit_write(1'b1); lit_read(32'd0, 1'b1);
        drive(1'b0, 1'b1, 32'h000, 32'd0, 4'h0);         lit_read(32'hCAFEF00D, 1'b0);

        // Reset in the middle of a read.
        drive(1'b1, 1'b0, 32'h009, 32'h5A5A1234, 4'hF);
        drive(1'b0, 1'b1, 32'h009, 32'd0, 4'h0);
        drive(1'b0, 1'b0, 32'h000, 32'd0, 4'h0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        rel = e;
        for (int j = 1; j <= 4; j++) begin
            lit_chk_av[rel+j] = 1'b1;
            lit_av[rel+j]     = 1'b0;
        end
        repeat (4) drive(1'b0, 1'b0, 32'h000, 32'd0, 4'h0);
        drive(1'b0, 1'b1, 32'h009, 32'd0, 4'h0);        lit_read(32'h5A5A1234, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            if ((i % 400) == 399) begin
                drive(1'b0, 1'b0, 32'h000, 32'd0, 4'h0);
                rst_n = 1'b0;
                repeat (1 + ($urandom % 2)) @(negedge clk);
                #1 rst_n = 1'b1;
            end else begin
                case ($urandom % 8)
                    0:       ra = $urandom | 32'h0000_1000;
                    1:       ra = 32'h8000_0000 | $urandom_range(0, 31);
                    default: ra = $urandom_range(0, 31);
                endcase
                drive($urandom % 2, $urandom % 2, ra, $urandom, 4'($urandom));
            end
        end
        repeat (6) drive(1'b0, 1'b0, 32'h000, 32'd0, 4'h0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_memory.md
PIPELINED_MEMORY -- requirements
Module: pipelined_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_BITS, default 12, number of implemented word-address bits; depth = 2^ADDR_BITS words.
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from read accept to data valid; legal range 1..4.
REQ-004 SHALL have port clk, input, 1 bit: single global clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-007 SHALL have port addr, input, 32 bits: word address.
REQ-008 SHALL have port wr, input, 1 bit: write request, sampled each cycle.
REQ-009 SHALL have port rd, input, 1 bit: read request, sampled each cycle.
REQ-010 SHALL have port byte_en, input, DATA_WIDTH/8 bits: per-byte write enable; bit i covers data bits [8i+7:8i].
REQ-011 SHALL have port data_out, output, DATA_WIDTH bits: read data.
REQ-012 SHALL have port available, output, 1 bit: data_out valid this cycle.
REQ-013 SHALL have port write_done, output, 1 bit: one-cycle write acknowledge.
REQ-014 SHALL have port addr_err, output, 1 bit: the response in this cycle targeted an out-of-range address.

Function
REQ-015 SHALL accept a request every cycle with no backpressure: fully pipelined, one read and/or one write per cycle.
REQ-016 SHALL treat addr as out of range when any addr bit at or above ADDR_BITS is 1; otherwise index storage with addr[ADDR_BITS-1:0].
REQ-017 On an in-range write, SHALL update only the bytes whose byte_en bit is 1 at the rising edge where wr is sampled high; byte_en = 0 writes nothing but still acknowledges.
REQ-018 SHALL assert write_done for exactly one cycle, starting the cycle after every accepted write, in range or not.
REQ-019 SHALL assert available for exactly one cycle READ_LATENCY cycles after each edge where rd is sampled high; back-to-back reads give back-to-back available pulses in request order.
REQ-020 SHALL drive data_out to zero whenever available is 0.
REQ-021 When wr and rd are both high in one cycle, SHALL perform both; the read returns the pre-write contents (read-before-write), including for the same address.
REQ-022 A read issued in a cycle after a write completes SHALL return the written data.
REQ-023 An out-of-range write SHALL leave storage unchanged; addr_err SHALL pulse with its write_done.
REQ-024 An out-of-range read SHALL return data_out = 0 with available = 1; addr_err SHALL pulse with that available.
REQ-025 When an errored write and an errored read respond in the same cycle, addr_err SHALL be a single 1 (OR of both sources).
REQ-026 SHALL use a READ_LATENCY-deep valid/data/error shift pipeline; the storage array read occupies the first stage.

Reset
REQ-027 While rst_n = 0: available = 0, write_done = 0, addr_err = 0, data_out = 0, and all pipeline valid bits cleared, asynchronously.
REQ-028 Storage contents SHALL NOT be reset; they are retained across reset.
REQ-029 Reset asserted mid-read SHALL flush all in-flight reads: no available pulse for any read accepted before reset.
REQ-030 Requests SHALL be accepted from the first rising edge with rst_n = 1.

Verification
REQ-031 Write 0xDEADBEEF to addr 0x005 with byte_en = 0xF, then read 0x005 -> write_done one cycle later; available exactly 2 cycles after rd, data_out = 0xDEADBEEF, addr_err = 0.
REQ-032 Location holds 0x11223344; write 0xAABBCCDD with byte_en = 0x5; read back -> 0x11BB33DD.
REQ-033 Reads to 0x001, 0x002, 0x003 on consecutive cycles -> three consecutive available pulses with matching data in order; repeat with READ_LATENCY = 1 and READ_LATENCY = 4.
REQ-034 Same cycle wr = 1 and rd = 1 to addr 0x010 (old 0x0, new 0x12345678) -> read returns 0x0; following read returns 0x12345678.
REQ-035 Write and read to addr 0x00001000 (ADDR_BITS = 12) -> storage at 0x000 unchanged; write_done with addr_err = 1; read returns 0 with available = 1 and addr_err = 1.
REQ-036 Issue a read, assert rst_n = 0 one cycle later, release -> no available pulse; a read of a previously written location after release still returns the pre-reset data.
